// File: rtl/cdb_scheduler.sv
// -----------------------------------------------------------------------------
// cdb_scheduler
//   Arbitrates the single Common Data Bus between NUM_SRC functional units.
//   In each cycle one pending result is granted. The oldest instruction wins.
//   The granted result is broadcast one cycle later from registers: the tag and
//   data go to the reservation stations, and RD/wren_banco drive the register
//   bank write port.
//
// Optional feature (compile-time macro CDB_STARVE_GUARD_EN):
//   Adds a saturating wait counter for each source. A source whose counter has
//   reached STARVE_MAX overrides age order. Among several starved sources, the
//   lowest index wins. When the macro is undefined, the block uses pure age
//   order with an index tie-break, and no counters exist.
//
// Ports
//   CLK         in   clock, rising edge
//   CLR         in   asynchronous reset, active-low
//   flush       in   drop this cycle's grant, so no broadcast happens next cycle
//   src_valid   in   [NUM_SRC]          result pending, one bit per source
//   src_ready   out  [NUM_SRC]          grant, one-hot or zero, combinational
//   src_data    in   [NUM_SRC*DATA_W]   result, source i at [i*DATA_W +: DATA_W]
//   src_tag     in   [NUM_SRC*TAG_W]    producing reservation-station id
//   src_rd      in   [NUM_SRC*RD_W]     destination register index
//   src_rd_we   in   [NUM_SRC]          1 = write the register bank (0 for stores)
//   src_seq     in   [NUM_SRC*SEQ_W]    issue sequence number (wraps)
//   cdb_valid   out  broadcast valid, registered
//   cdb_tag     out  [TAG_W]  broadcast tag
//   cdb_data    out  [DATA_W] broadcast data
//   wren_banco  out  register-bank write enable, registered
//   RD          out  [RD_W]   register-bank write index
// -----------------------------------------------------------------------------
module cdb_scheduler #(
  parameter int NUM_SRC    = 3,
  parameter int DATA_W     = 16,
  parameter int TAG_W      = 4,
  parameter int RD_W       = 3,
  parameter int SEQ_W      = 10,
  parameter int STARVE_MAX = 15
) (
  input  logic                      CLK,
  input  logic                      CLR,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
  input  logic [NUM_SRC*RD_W-1:0]   src_rd,
  input  logic [NUM_SRC-1:0]        src_rd_we,
  input  logic [NUM_SRC*SEQ_W-1:0]  src_seq,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic                      wren_banco,
  output logic [RD_W-1:0]           RD
);

  localparam int IDX_W = $clog2(NUM_SRC);

  // Reject unsupported configurations when the design is elaborated.
  if (NUM_SRC < 2 || NUM_SRC > 8 || STARVE_MAX < 1 || SEQ_W < 2) begin : g_bad_cfg
    $error("cdb_scheduler: unsupported parameter set");
  end

  // ---------------------------------------------------------------------------
  // Split the flat source buses into per-source arrays
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] data_arr [NUM_SRC];
  logic [TAG_W-1:0]  tag_arr  [NUM_SRC];
  logic [RD_W-1:0]   rd_arr   [NUM_SRC];
  logic [SEQ_W-1:0]  seq_arr  [NUM_SRC];

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
    assign data_arr[gi] = src_data[gi*DATA_W +: DATA_W];
    assign tag_arr[gi]  = src_tag[gi*TAG_W +: TAG_W];
    assign rd_arr[gi]   = src_rd[gi*RD_W +: RD_W];
    assign seq_arr[gi]  = src_seq[gi*SEQ_W +: SEQ_W];
  end

  // a is older than b when (a - b) mod 2^SEQ_W has its MSB set. This stays
  // correct across wrap-around, because in-flight seqs span less than half
  // of the number space.
  function automatic logic is_older(input logic [SEQ_W-1:0] a,
                                    input logic [SEQ_W-1:0] b);
    logic [SEQ_W-1:0] diff;
    diff = a - b;
    return diff[SEQ_W-1];
  endfunction

  // ---------------------------------------------------------------------------
  // Optional starvation guard
  // ---------------------------------------------------------------------------
  logic [NUM_SRC-1:0] starved;

`ifdef CDB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_starve
    logic [CNT_W-1:0] wait_q;
    logic [CNT_W-1:0] wait_d;

    assign starved[gi] = src_valid[gi] && (wait_q == CNT_W'(STARVE_MAX));

    always_comb begin
      wait_d = wait_q;
      if (flush || !src_valid[gi] || src_ready[gi]) begin
        wait_d = '0;
      end else if (wait_q != CNT_W'(STARVE_MAX)) begin
        wait_d = wait_q + 1'b1;
      end
    end

    always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
        wait_q <= '0;
      end else begin
        wait_q <= wait_d;
      end
    end
  end
`else
  assign starved = '0;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic             found;
  logic             starve_found;
  logic [IDX_W-1:0] win_idx;
  logic [SEQ_W-1:0] win_seq;
  logic             grant_any;

  always_comb begin
    found        = 1'b0;
    starve_found = 1'b0;
    win_idx      = '0;
    win_seq      = '0;
    // Scan the sources in index order. A later source replaces the current
    // winner only when it is strictly older, so equal seqs go to the lowest
    // index.
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_valid[i] && (!found || is_older(seq_arr[i], win_seq))) begin
        found   = 1'b1;
        win_idx = IDX_W'(i);
        win_seq = seq_arr[i];
      end
    end
    // A starved source overrides age order. The lowest starved index wins.
    for (int i = 0; i < NUM_SRC; i++) begin
      if (starved[i] && !starve_found) begin
        starve_found = 1'b1;
        win_idx      = IDX_W'(i);
      end
    end
  end

  // While CLR is low, no grant is issued, because it would be lost anyway.
  assign grant_any = found && !flush && CLR;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ready
    assign src_ready[gi] = grant_any && (win_idx == IDX_W'(gi));
  end

  // ---------------------------------------------------------------------------
  // Broadcast registers
  // ---------------------------------------------------------------------------
  logic              cdb_valid_q, cdb_valid_d;
  logic              wren_q,      wren_d;
  logic [TAG_W-1:0]  tag_q,       tag_d;
  logic [DATA_W-1:0] data_q,      data_d;
  logic [RD_W-1:0]   rd_q,        rd_d;

  always_comb begin
    cdb_valid_d = grant_any;
    wren_d      = 1'b0;
    tag_d       = tag_q;
    data_d      = data_q;
    rd_d        = rd_q;
    if (grant_any) begin
      wren_d = src_rd_we[win_idx];
      tag_d  = tag_arr[win_idx];
      data_d = data_arr[win_idx];
      rd_d   = rd_arr[win_idx];
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      cdb_valid_q <= 1'b0;
      wren_q      <= 1'b0;
      tag_q       <= '0;
      data_q      <= '0;
      rd_q        <= '0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      wren_q      <= wren_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      rd_q        <= rd_d;
    end
  end

  assign cdb_valid  = cdb_valid_q;
  assign wren_banco = wren_q;
  assign cdb_tag    = tag_q;
  assign cdb_data   = data_q;
  assign RD         = rd_q;

endmodule
